// File: rtl/glyph_fetch_pkg.sv
// Shared VGA text-mode definitions: colours, tile geometry, tile-byte layout
// and the constant-multiplier helper used for tile addressing.
package glyph_fetch_pkg;

    localparam int TILE_SIZE  = 16;
    localparam int VGA_COLS   = 40;
    localparam int VGA_ROWS   = 30;

    localparam logic [7:0] BLACK = 8'b000_000_00;
    localparam logic [7:0] WHITE = 8'b111_111_11;
    localparam logic [7:0] GREEN = 8'b000_111_00;
    localparam logic [7:0] BLUE  = 8'b000_000_11;
    localparam logic [7:0] RED   = 8'b111_000_00;

    // Tile byte: [7] blink, [6:5] colour select, [4:0] glyph index
    localparam int GLYPH_LSB  = 0;
    localparam int GLYPH_MSB  = 4;
    localparam int COLOUR_LSB = 5;
    localparam int COLOUR_MSB = 6;
    localparam int BLINK_POS  = 7;

    typedef enum logic [1:0] {
        SEL_WHITE = 2'd0,
        SEL_GREEN = 2'd1,
        SEL_BLUE  = 2'd2,
        SEL_RED   = 2'd3
    } colourSel_t;

    function automatic logic [7:0] colourOf(input logic [1:0] sel);
        case (colourSel_t'(sel))
            SEL_WHITE: colourOf = WHITE;
            SEL_GREEN: colourOf = GREEN;
            SEL_BLUE:  colourOf = BLUE;
            default:   colourOf = RED;
        endcase
    endfunction

    // row * cols as a sum of shifted copies (cols is a constant, so this
    // collapses to a couple of adders; 40 -> row*32 + row*8)
    function automatic logic [10:0] rowBase(input logic [4:0] row, input int cols);
        logic [10:0] acc;
        acc = '0;
        for (int i = 0; i < 11; i++) begin
            if (cols[i]) acc = acc + (11'(row) << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/glyph_fetch_if.sv
// Tile RAM / glyph ROM read bus. No handshake: the master issues one address
// per clk and the memory returns its data exactly one clk later.
interface glyph_fetch_if;
    logic [10:0] tileAddr;
    logic [7:0]  tileData;
    logic [8:0]  glyphAddr;
    logic [15:0] glyphData;

    modport master (output tileAddr, output glyphAddr, input tileData, input glyphData);
    modport slave  (input tileAddr, input glyphAddr, output tileData, output glyphData);
endinterface

// File: rtl/glyph_fetch.sv
// Text-mode glyph fetcher: four-stage pipeline from timing-generator coordinates
// to a registered RRR_GGG_BB pixel, with syncs and bright delayed to match.
module glyph_fetch
    import glyph_fetch_pkg::*;
#(
    parameter int COLS      = VGA_COLS,
    parameter int ROWS      = VGA_ROWS,
    parameter int BLINK_BIT = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    hCount,
    input  logic [9:0]    vCount,
    input  logic          bright,
    input  logic          hSync,
    input  logic          vSync,
    glyph_fetch_if.master mem,
    output logic [7:0]    rgb,
    output logic          hSyncOut,
    output logic          vSyncOut,
    output logic          brightOut,
    output logic [5:0]    frameCount
);

    localparam logic [10:0] H_END = 11'(COLS * TILE_SIZE);
    localparam logic [10:0] V_END = 11'(ROWS * TILE_SIZE);

    logic [9:0]  h1, v1, h2, v2, h3, v3;
    logic        b1, b2, b3;
    logic [1:0]  colour3;
    logic        blink3;
    logic [3:0]  hsDly, vsDly;
    logic        inRange0;
    logic [10:0] addrNext;
    logic        pixelOn;
    logic        blank;

    // Out-of-range coordinates fetch tile 0; the stage-3 range check blanks them
    always_comb begin
        inRange0 = ({1'b0, hCount} < H_END) && ({1'b0, vCount} < V_END);
        addrNext = '0;
        if (inRange0) addrNext = rowBase(vCount[8:4], COLS) + 11'(hCount[9:4]);
    end

    // Each stage carries its own coordinate copy so the hCount wrap needs no special case
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.tileAddr <= '0;
            h1 <= '0; v1 <= '0; b1 <= 1'b0;
            h2 <= '0; v2 <= '0; b2 <= 1'b0;
            h3 <= '0; v3 <= '0; b3 <= 1'b0;
            colour3 <= '0;
            blink3  <= 1'b0;
        end else begin
            mem.tileAddr <= addrNext;
            h1 <= hCount; v1 <= vCount; b1 <= bright;
            h2 <= h1;     v2 <= v1;     b2 <= b1;
            h3 <= h2;     v3 <= v2;     b3 <= b2;
            colour3 <= mem.tileData[COLOUR_MSB:COLOUR_LSB];
            blink3  <= mem.tileData[BLINK_POS];
        end
    end

    assign mem.glyphAddr = {mem.tileData[GLYPH_MSB:GLYPH_LSB], v2[3:0]};

    always_comb begin
        pixelOn = mem.glyphData[~h3[3:0]];
        blank   = !b3
               || ({1'b0, h3} >= H_END)
               || ({1'b0, v3} >= V_END)
               || (blink3 && frameCount[BLINK_BIT]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsDly      <= '1;
            vsDly      <= '1;
            rgb        <= BLACK;
            brightOut  <= 1'b0;
            frameCount <= '0;
        end else begin
            hsDly     <= {hsDly[2:0], hSync};
            vsDly     <= {vsDly[2:0], vSync};
            brightOut <= b3;
            rgb       <= (pixelOn && !blank) ? colourOf(colour3) : BLACK;
            // vsDly[0] is the registered vSync; falling edge when the older copy is still high
            if (vsDly[1] && !vsDly[0]) frameCount <= frameCount + 6'd1;
        end
    end

    assign hSyncOut = hsDly[3];
    assign vSyncOut = vsDly[3];

endmodule

// File: tb/tb_glyph_fetch.sv
// Directed bench for glyph_fetch with behavioural tile RAM and glyph ROM.
module tb_glyph_fetch;
    import glyph_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] hCount = '0;
    logic [9:0] vCount = '0;
    logic       bright = 1'b0;
    logic       hSync = 1'b1;
    logic       vSync = 1'b1;
    logic [7:0] rgb;
    logic       hSyncOut, vSyncOut, brightOut;
    logic [5:0] frameCount;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tileMem  [0:2047];
    logic [15:0] glyphMem [0:511];
    int          wrapH [4] = '{638, 639, 0, 1};
    logic [7:0]  wrapE [4];

    glyph_fetch_if mem();

    glyph_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hCount     (hCount),
        .vCount     (vCount),
        .bright     (bright),
        .hSync      (hSync),
        .vSync      (vSync),
        .mem        (mem),
        .rgb        (rgb),
        .hSyncOut   (hSyncOut),
        .vSyncOut   (vSyncOut),
        .brightOut  (brightOut),
        .frameCount (frameCount)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        mem.tileData  <= tileMem[mem.tileAddr];
        mem.glyphData <= glyphMem[mem.glyphAddr];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRgb(input string tag, input logic [7:0] exp);
        check(tag, {8'h00, rgb}, {8'h00, exp});
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        check(tag, {15'h0, obs}, {15'h0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int h, input int v, input logic b);
        hCount = 10'(h);
        vCount = 10'(v);
        bright = b;
    endtask

    task automatic pix4(input int h, input int v, input logic b, input logic [7:0] exp, input string tag);
        pixel(h, v, b);
        repeat (4) step();
        checkRgb(tag, exp);
    endtask

    task automatic fillTiles(input logic [7:0] val);
        for (int i = 0; i < 2048; i++) tileMem[i] = val;
    endtask

    task automatic fillGlyphs(input logic [15:0] val);
        for (int i = 0; i < 512; i++) glyphMem[i] = val;
    endtask

    task automatic vsPulse();
        vSync = 1'b0;
        step();
        vSync = 1'b1;
        repeat (3) step();
    endtask

    function automatic logic [7:0] expFirst(input int h);
        if (h == 0) return GREEN;
        if (h == 31) return BLUE;
        return BLACK;
    endfunction

    initial begin
        wrapE = '{BLACK, RED, GREEN, BLACK};
        fillTiles(8'h00);
        fillGlyphs(16'h0000);

        // reset state
        #1 rst_n = 1'b0;
        step();
        step();
        checkRgb("reset rgb", BLACK);
        checkBit("reset hSyncOut", hSyncOut, 1'b1);
        checkBit("reset vSyncOut", vSyncOut, 1'b1);
        checkBit("reset brightOut", brightOut, 1'b0);
        check("reset frameCount", {10'h0, frameCount}, 16'd0);
        check("reset tileAddr", {5'h0, mem.tileAddr}, 16'd0);
        rst_n = 1'b1;
        step();

        // first tiles streamed one pixel per clk
        fillTiles(8'h21);
        tileMem[1]  = 8'h42;
        tileMem[39] = 8'h60;
        glyphMem[16] = 16'h8000;
        glyphMem[32] = 16'h0001;
        glyphMem[0]  = 16'h0001;
        for (int i = 0; i < 35; i++) begin
            if (i < 32) pixel(i, 0, 1'b1);
            step();
            if (i >= 3) checkRgb($sformatf("first_tile h=%0d", i - 3), expFirst(i - 3));
        end
        checkBit("stream brightOut", brightOut, 1'b1);

        // hCount wrap from last column to 0 without a bubble
        for (int i = 0; i < 7; i++) begin
            if (i < 4) pixel(wrapH[i], 0, 1'b1);
            step();
            if (i >= 3) checkRgb($sformatf("wrap h=%0d", wrapH[i - 3]), wrapE[i - 3]);
        end

        // tile addressing and out-of-range clamp
        pixel(639, 479, 1'b1); step();
        check("addr 639/479", {5'h0, mem.tileAddr}, 16'd1199);
        pixel(16, 16, 1'b1); step();
        check("addr 16/16", {5'h0, mem.tileAddr}, 16'd41);
        pixel(700, 0, 1'b1); step();
        check("addr h700", {5'h0, mem.tileAddr}, 16'd0);
        pixel(0, 480, 1'b1); step();
        check("addr v480", {5'h0, mem.tileAddr}, 16'd0);

        fillTiles(8'h00);
        fillGlyphs(16'hFFFF);
        pix4(5, 0, 1'b1, WHITE, "inrange white");
        pix4(700, 0, 1'b1, BLACK, "h700 black");
        pix4(0, 480, 1'b1, BLACK, "v480 black");

        // sync alignment: single-cycle hSync low pulse
        pixel(0, 0, 1'b1);
        step();
        hSync = 1'b0;
        step();
        hSync = 1'b1;
        checkBit("hsync edge1", hSyncOut, 1'b1);
        step(); checkBit("hsync edge2", hSyncOut, 1'b1);
        step(); checkBit("hsync edge3", hSyncOut, 1'b1);
        step(); checkBit("hsync edge4", hSyncOut, 1'b0);
        step(); checkBit("hsync edge5", hSyncOut, 1'b1);

        // bright low blanks regardless of glyph data
        pix4(0, 0, 1'b0, BLACK, "bright0 black");
        checkBit("bright0 brightOut", brightOut, 1'b0);
        pix4(0, 0, 1'b1, WHITE, "bright1 white");
        checkBit("bright1 brightOut", brightOut, 1'b1);

        // blink over 64 vSync falling edges
        fillTiles(8'hE0);
        pix4(0, 0, 1'b1, RED, "blink fc=0");
        check("blink frameCount 0", {10'h0, frameCount}, 16'd0);
        for (int k = 1; k <= 64; k++) begin
            vsPulse();
            pix4(0, 0, 1'b1, ((k % 64) < 32) ? RED : BLACK, $sformatf("blink k=%0d", k));
            check($sformatf("frameCount k=%0d", k), {10'h0, frameCount}, 16'(k % 64));
        end

        // reset in the middle of active video
        fillTiles(8'h21);
        vsPulse();
        check("pre-reset frameCount", {10'h0, frameCount}, 16'd1);
        pix4(0, 0, 1'b1, GREEN, "pre-reset green");
        hSync = 1'b0;
        vSync = 1'b0;
        repeat (5) step();
        checkBit("pre-reset hSyncOut", hSyncOut, 1'b0);
        checkBit("pre-reset vSyncOut", vSyncOut, 1'b0);
        #5 rst_n = 1'b0;
        #1;
        checkRgb("midreset rgb", BLACK);
        checkBit("midreset hSyncOut", hSyncOut, 1'b1);
        checkBit("midreset vSyncOut", vSyncOut, 1'b1);
        checkBit("midreset brightOut", brightOut, 1'b0);
        check("midreset frameCount", {10'h0, frameCount}, 16'd0);
        check("midreset tileAddr", {5'h0, mem.tileAddr}, 16'd0);
        hSync = 1'b1;
        vSync = 1'b1;
        step();
        step();
        checkRgb("held reset rgb", BLACK);
        rst_n = 1'b1;
        pixel(0, 0, 1'b1);
        step(); checkRgb("post-reset edge1", BLACK);
        step(); checkRgb("post-reset edge2", BLACK);
        step(); checkRgb("post-reset edge3", BLACK);
        step(); checkRgb("post-reset edge4", GREEN);
        checkBit("post-reset brightOut", brightOut, 1'b1);
        check("post-reset frameCount", {10'h0, frameCount}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
